// File: rtl/evm_pkg.sv
// Shared defaults and helpers for the multi-channel push-button debouncer.
package evm_pkg;

    localparam int DEF_N_CH          = 4;
    localparam int DEF_STABLE_CYCLES = 4;

    // Index width for a channel number, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debouncer_n_if.sv
// Button bus: raw levels in, debounced levels, edge pulses and press vote out.
interface button_debouncer_n_if #(
    parameter int N_CH   = 4,
    parameter int CODE_W = 2
);

    logic [N_CH-1:0]   din;
    logic [N_CH-1:0]   level;
    logic [N_CH-1:0]   press_pulse;
    logic [N_CH-1:0]   release_pulse;
    logic              press_valid;
    logic [CODE_W-1:0] press_code;
    logic              multi_press;

    modport master (
        output din,
        input  level,
        input  press_pulse,
        input  release_pulse,
        input  press_valid,
        input  press_code,
        input  multi_press
    );

    modport slave (
        input  din,
        output level,
        output press_pulse,
        output release_pulse,
        output press_valid,
        output press_code,
        output multi_press
    );

endinterface

// File: rtl/debounce_channel.sv
// One button: two-flop synchroniser, stability counter, level and edge pulses.
module debounce_channel #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic clock,
    input  logic Reset,
    input  logic i_din,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    // Any cycle where the synchronised input agrees with level restarts qualification
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_din;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt     <= '0;
                r_level   <= ~r_level;
                r_press   <= ~r_level;
                r_release <= r_level;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_debouncer_n.sv
// N-channel debouncer with a single-press encoder over the registered press pulses.
module button_debouncer_n
    import evm_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                clock,
    input  logic                Reset,
    button_debouncer_n_if.slave bus
);

    localparam int CODE_W = idx_w(N_CH);

    logic [N_CH-1:0]   w_level;
    logic [N_CH-1:0]   w_press;
    logic [N_CH-1:0]   w_release;
    logic [4:0]        w_ones;
    logic [CODE_W-1:0] w_idx;
    logic              w_valid;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clock     (clock),
            .Reset     (Reset),
            .i_din     (bus.din[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

    // Simultaneous presses are counted so the vote can be rejected downstream
    always_comb begin
        w_ones = '0;
        w_idx  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_press[i]) begin
                w_ones = w_ones + 5'd1;
                w_idx  = CODE_W'(i);
            end
        end
    end

    assign w_valid = (w_ones == 5'd1);

    assign bus.level         = w_level;
    assign bus.press_pulse   = w_press;
    assign bus.release_pulse = w_release;
    assign bus.press_valid   = w_valid;
    assign bus.press_code    = w_valid ? w_idx : '0;
    assign bus.multi_press   = (w_ones > 5'd1);

endmodule

// File: doc/button_debouncer_n.md
BUTTON_DEBOUNCER_N -- requirements
Module: button_debouncer_n

Interface
REQ-001 Parameter N_CH, default 4, number of independent push-button channels (1..16).
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive synchronised cycles a new level must persist before acceptance (>=1).
REQ-003 Parameter CNT_W, default $clog2(STABLE_CYCLES+1), width of each channel's stability counter.
REQ-004 Port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1, asynchronous active-high reset.
REQ-006 Port din, input, N_CH, raw asynchronous button levels, bit i = channel i.
REQ-007 Port level, output, N_CH, debounced stable level per channel.
REQ-008 Port press_pulse, output, N_CH, one-cycle pulse per channel when level rises 0->1.
REQ-009 Port release_pulse, output, N_CH, one-cycle pulse per channel when level falls 1->0.
REQ-010 Port press_valid, output, 1, exactly one press_pulse bit is set this cycle.
REQ-011 Port press_code, output, $clog2(N_CH) (min 1), index of the pressing channel; valid only with press_valid.
REQ-012 Port multi_press, output, 1, two or more press_pulse bits are set in the same cycle.

Function
REQ-013 Each channel SHALL pass din[i] through a two-flop synchroniser (sync1, sync2) before any other use.
REQ-014 Per channel: if sync2 equals level, the counter SHALL clear to 0.
REQ-015 If sync2 differs from level and counter < STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 If sync2 differs from level and counter == STABLE_CYCLES-1, level SHALL toggle and the counter SHALL clear; counter never exceeds STABLE_CYCLES-1 (no wrap).
REQ-017 A single mismatch-free cycle (glitch back to level) SHALL restart qualification from 0.
REQ-018 press_pulse[i] / release_pulse[i] SHALL be registered and asserted on exactly the edge at which level[i] toggles, for one cycle only.
REQ-019 Latency: din[i] stable from before edge 0 -> level[i] and pulse update at edge STABLE_CYCLES+1 (STABLE_CYCLES=4: edge 5, i.e. 6th edge counted from 0).
REQ-020 Holding a button SHALL produce exactly one press_pulse; no auto-repeat.
REQ-021 press_valid, press_code, multi_press SHALL be combinational from registered press_pulse (same cycle).
REQ-022 press_code SHALL be the index of the single set bit when press_valid=1, and 0 otherwise.
REQ-023 When >=2 press_pulse bits are set: multi_press=1, press_valid=0, press_code=0 (vote rejected downstream).
REQ-024 Channels SHALL be fully independent; simultaneous press on one channel and release on another SHALL both pulse normally.

Reset
REQ-025 Reset=1 SHALL asynchronously clear sync1, sync2, counters, level, press_pulse, release_pulse to 0; derived outputs consequently 0.
REQ-026 Reset asserted mid-qualification SHALL discard partial counts; after release, a held button re-qualifies from 0 and yields one press_pulse.
REQ-027 A button held through Reset deassertion SHALL produce press_pulse at edge STABLE_CYCLES+1 after the first post-reset edge.

Structure
REQ-028 Shared package evm_pkg SHALL hold default N_CH, STABLE_CYCLES and a helper for index width (max(1,$clog2(N_CH))).
REQ-029 Per-channel logic (synchroniser, counter, level, pulses) SHALL be sub-module debounce_channel, instantiated N_CH times via generate.
REQ-030 Press encoding (press_valid, press_code, multi_press) SHALL live in the top module.

Verification (N_CH=4, STABLE_CYCLES=4)
REQ-031 din=4'b0001 held from edge 0 -> level=4'b0001, press_pulse=4'b0001, press_valid=1, press_code=0 at edge 5 only; pulse low at edge 6.
REQ-032 din[2] toggles 1/0 every 2 cycles for 40 cycles -> level[2]=0, no pulses ever.
REQ-033 din=4'b1010 set at same edge, held -> multi_press=1, press_valid=0, press_code=0 at edge 5; level=4'b1010.
REQ-034 Channel 3 held high then released after level=1 -> release_pulse[3]=1 for one cycle STABLE_CYCLES+2 edges after release; no press_pulse.
REQ-035 din[1]=1 held, Reset pulsed at edge 3 (counter=1) -> all outputs 0 immediately; press_pulse[1] at edge 5 after deassertion, exactly once.
REQ-036 din[0] high 3 cycles, low 1, high again -> single press_pulse[0] 6 edges after final rise.
